// File: rtl/hazard_sequencer_if.sv
// Hazard sequencer bus: pipeline hazard requests and controls, plus the
// performance-counter read port and watchdog flag. The master side is the
// pipeline/host; the slave side is the hazard sequencer itself.
interface hazard_sequencer_if #(
  parameter int NUM_STAGES   = 5,
  parameter int NUM_REDIRECT = 2,
  parameter int PC_WIDTH     = 32,
  parameter int CNT_WIDTH    = 32,
  parameter int SEL_WIDTH    = 4
);
  logic [NUM_STAGES-2:0]            stall_req;
  logic [NUM_REDIRECT-1:0]          redirect_valid;
  logic [NUM_REDIRECT*PC_WIDTH-1:0] redirect_target;
  logic [NUM_STAGES-1:0]            hc_stall;
  logic [NUM_STAGES-1:0]            hc_flush;
  logic                             load_pc_we;
  logic [PC_WIDTH-1:0]              load_pc_new_pc;
  logic [SEL_WIDTH-1:0]             cnt_sel;
  logic                             cnt_clear;
  logic [CNT_WIDTH-1:0]             cnt_rdata;
  logic                             wdog_timeout;

  modport master (
    output stall_req, redirect_valid, redirect_target, cnt_sel, cnt_clear,
    input  hc_stall, hc_flush, load_pc_we, load_pc_new_pc, cnt_rdata, wdog_timeout
  );

  modport slave (
    input  stall_req, redirect_valid, redirect_target, cnt_sel, cnt_clear,
    output hc_stall, hc_flush, load_pc_we, load_pc_new_pc, cnt_rdata, wdog_timeout
  );
endinterface

// File: rtl/hazard_sequencer.sv
// Hazard sequencer for an in-order pipeline of arbitrary depth.
// Stall/flush/PC-load controls are combinational; performance counters,
// the counter read port and the fetch-starvation watchdog are registered.
// Redirect sources must sit at stage 1 or later (REDIR_BASE >= 1) so that
// their stall gating never depends on the PC load they produce.
module hazard_sequencer #(
  parameter int NUM_STAGES   = 5,
  parameter int NUM_REDIRECT = 2,
  parameter int REDIR_BASE   = 1,
  parameter int DELAY_SLOT   = 1,
  parameter int PC_WIDTH     = 32,
  parameter int CNT_WIDTH    = 32,
  parameter int SEL_WIDTH    = 4,
  parameter int WDOG_LIMIT   = 1024
) (
  input logic               clk,
  input logic               rst_n,
  hazard_sequencer_if.slave bus
);

  localparam int NUM_CNT = NUM_STAGES + NUM_REDIRECT;
  localparam int STG_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int RED_W   = (NUM_REDIRECT > 1) ? $clog2(NUM_REDIRECT) : 1;
  localparam int WDOG_W  = (WDOG_LIMIT > 0) ? $clog2(WDOG_LIMIT + 1) : 1;
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_LIMIT);
  localparam logic              WDOG_EN  = (WDOG_LIMIT != 0) ? 1'b1 : 1'b0;

  // Saturating increment: all-ones sticks.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    sat_inc = (&v) ? v : (v + CNT_WIDTH'(1));
  endfunction

  logic [NUM_STAGES-1:0]  stall_ext_s;
  logic [NUM_STAGES-1:0]  hc_stall_s;
  logic [NUM_STAGES-1:0]  hc_flush_s;
  logic [NUM_REDIRECT-1:0] accept_s;
  logic                   load_pc_we_s;
  logic [PC_WIDTH-1:0]    new_pc_s;
  logic [RED_W-1:0]       winner_idx_s;
  logic [STG_W-1:0]       winner_stage_s;
  logic [NUM_CNT-1:0]     cnt_inc_s;
  logic [CNT_WIDTH-1:0]   rd_mux_s;
  logic                   fetch_starve_s;
  logic [WDOG_W-1:0]      wdog_next_s;

  logic [CNT_WIDTH-1:0]   cnt_r [NUM_CNT];
  logic [CNT_WIDTH-1:0]   cnt_rdata_r;
  logic [WDOG_W-1:0]      wdog_cnt_r;
  logic                   wdog_timeout_r;

  // Stall chain from writeback back to decode, then redirect arbitration,
  // then the fetch stall (a redirect overrides a fetch miss, not a downstream stall).
  always_comb begin
    stall_ext_s    = {1'b0, bus.stall_req};
    hc_stall_s     = '0;
    for (int i = NUM_STAGES - 2; i >= 1; i--) begin
      hc_stall_s[i] = stall_ext_s[i] | hc_stall_s[i+1];
    end
    accept_s       = '0;
    load_pc_we_s   = 1'b0;
    new_pc_s       = '0;
    winner_idx_s   = '0;
    winner_stage_s = '0;
    // Ascending scan: the last accepted source (oldest) wins.
    for (int r = 0; r < NUM_REDIRECT; r++) begin
      accept_s[r]    = bus.redirect_valid[r] & ~hc_stall_s[REDIR_BASE+r];
      load_pc_we_s   = load_pc_we_s | accept_s[r];
      new_pc_s       = accept_s[r] ? bus.redirect_target[r*PC_WIDTH +: PC_WIDTH] : new_pc_s;
      winner_idx_s   = accept_s[r] ? RED_W'(r) : winner_idx_s;
      winner_stage_s = accept_s[r] ? STG_W'(REDIR_BASE + r) : winner_stage_s;
    end
    hc_stall_s[0] = (stall_ext_s[0] & ~load_pc_we_s) | hc_stall_s[1];
  end

  // Flushes: bubble behind a stage that stalls while its successor moves,
  // plus the wrong-path stages younger than the winning redirect.
  always_comb begin
    hc_flush_s = '0;
    for (int i = 0; i <= NUM_STAGES - 2; i++) begin
      hc_flush_s[i+1] = stall_ext_s[i] & ~hc_stall_s[i+1];
    end
    for (int k = 1; k < NUM_STAGES; k++) begin
      hc_flush_s[k] = hc_flush_s[k] |
                      (load_pc_we_s & ((k + DELAY_SLOT) <= int'(winner_stage_s)));
    end
  end

  // Per-counter increment enables and the watchdog starvation condition.
  always_comb begin
    cnt_inc_s    = '0;
    cnt_inc_s[0] = 1'b1;
    for (int i = 0; i <= NUM_STAGES - 2; i++) begin
      cnt_inc_s[1+i] = stall_ext_s[i];
    end
    for (int r = 0; r < NUM_REDIRECT; r++) begin
      cnt_inc_s[NUM_STAGES+r] = load_pc_we_s & (winner_idx_s == RED_W'(r));
    end
    fetch_starve_s = hc_stall_s[0] & ~load_pc_we_s;
    wdog_next_s    = (wdog_cnt_r == WDOG_MAX) ? WDOG_MAX : (wdog_cnt_r + WDOG_W'(1));
  end

  // Counter read mux; unmatched selects read zero.
  always_comb begin
    rd_mux_s = '0;
    for (int j = 0; j < NUM_CNT; j++) begin
      rd_mux_s = (bus.cnt_sel == SEL_WIDTH'(j)) ? cnt_r[j] : rd_mux_s;
    end
  end

  // Saturating performance counters with synchronous clear priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NUM_CNT; j++) cnt_r[j] <= '0;
    end else if (bus.cnt_clear) begin
      for (int j = 0; j < NUM_CNT; j++) cnt_r[j] <= '0;
    end else begin
      for (int j = 0; j < NUM_CNT; j++) begin
        if (cnt_inc_s[j]) cnt_r[j] <= sat_inc(cnt_r[j]);
      end
    end
  end

  // Registered counter read port (shows pre-increment values).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_rdata_r <= '0;
    end else begin
      cnt_rdata_r <= rd_mux_s;
    end
  end

  // Fetch-starvation watchdog with sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt_r     <= '0;
      wdog_timeout_r <= 1'b0;
    end else if (bus.cnt_clear) begin
      wdog_cnt_r     <= '0;
      wdog_timeout_r <= 1'b0;
    end else if (fetch_starve_s) begin
      wdog_cnt_r <= wdog_next_s;
      if (WDOG_EN && (wdog_next_s == WDOG_MAX)) wdog_timeout_r <= 1'b1;
    end else begin
      wdog_cnt_r <= '0;
    end
  end

  assign bus.hc_stall       = hc_stall_s;
  assign bus.hc_flush       = hc_flush_s;
  assign bus.load_pc_we     = load_pc_we_s;
  assign bus.load_pc_new_pc = new_pc_s;
  assign bus.cnt_rdata      = cnt_rdata_r;
  assign bus.wdog_timeout   = wdog_timeout_r;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed scoreboard bench for hazard_sequencer: dut_a uses delay slots
// and an 8-cycle watchdog, dut_b has no delay slot.
module tb_hazard_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;

  exp_t sb_q[$];

  hazard_sequencer_if #(.NUM_STAGES(5), .NUM_REDIRECT(2), .PC_WIDTH(32),
                        .CNT_WIDTH(32), .SEL_WIDTH(4)) bus_a ();
  hazard_sequencer_if #(.NUM_STAGES(5), .NUM_REDIRECT(2), .PC_WIDTH(32),
                        .CNT_WIDTH(32), .SEL_WIDTH(4)) bus_b ();

  hazard_sequencer #(.NUM_STAGES(5), .NUM_REDIRECT(2), .REDIR_BASE(1), .DELAY_SLOT(1),
                     .PC_WIDTH(32), .CNT_WIDTH(32), .SEL_WIDTH(4), .WDOG_LIMIT(8))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

  hazard_sequencer #(.NUM_STAGES(5), .NUM_REDIRECT(2), .REDIR_BASE(1), .DELAY_SLOT(0),
                     .PC_WIDTH(32), .CNT_WIDTH(32), .SEL_WIDTH(4), .WDOG_LIMIT(1024))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running, expected done");
    $fatal(1);
  end

  task automatic push_exp(input string tag, input logic [63:0] e);
    exp_t item;
    item.tag = tag;
    item.exp = e;
    sb_q.push_back(item);
  endtask

  task automatic pop_chk(input logic [63:0] obs);
    exp_t item;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed 0x%0h with no expected entry", obs);
    end else begin
      item = sb_q.pop_front();
      assert (obs === item.exp) else begin
        errors++;
        $error("FAIL %s: observed 0x%0h, expected 0x%0h", item.tag, obs, item.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus_a.stall_req = '0; bus_a.redirect_valid = '0; bus_a.redirect_target = '0;
    bus_a.cnt_sel = '0;   bus_a.cnt_clear = 1'b0;
    bus_b.stall_req = '0; bus_b.redirect_valid = '0; bus_b.redirect_target = '0;
    bus_b.cnt_sel = '0;   bus_b.cnt_clear = 1'b0;

    // Reset state
    step();
    step();
    push_exp("rst_rdata", 64'h0);
    push_exp("rst_wdog", 64'h0);
    push_exp("rst_stall", 64'h0);
    pop_chk(64'(bus_a.cnt_rdata));
    pop_chk(64'(bus_a.wdog_timeout));
    pop_chk(64'(bus_a.hc_stall));
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // I-cache miss
    bus_a.stall_req = 4'b0001;
    push_exp("icmiss_stall", 64'h01);
    push_exp("icmiss_flush", 64'h02);
    push_exp("icmiss_we", 64'h0);
    #1;
    pop_chk(64'(bus_a.hc_stall));
    pop_chk(64'(bus_a.hc_flush));
    pop_chk(64'(bus_a.load_pc_we));
    step();

    // Load-use with gated decode redirect, then release
    bus_a.stall_req = 4'b0010;
    bus_a.redirect_valid = 2'b01;
    bus_a.redirect_target = {32'h0000_0000, 32'h0000_0040};
    push_exp("lu_stall", 64'h03);
    push_exp("lu_flush", 64'h04);
    push_exp("lu_we", 64'h0);
    #1;
    pop_chk(64'(bus_a.hc_stall));
    pop_chk(64'(bus_a.hc_flush));
    pop_chk(64'(bus_a.load_pc_we));
    step();
    bus_a.stall_req = 4'b0000;
    push_exp("lu_rel_we", 64'h1);
    push_exp("lu_rel_pc", 64'h40);
    push_exp("lu_rel_flush", 64'h00);
    #1;
    pop_chk(64'(bus_a.load_pc_we));
    pop_chk(64'(bus_a.load_pc_new_pc));
    pop_chk(64'(bus_a.hc_flush));
    step();

    // Two redirects over a fetch miss; older wins
    bus_a.redirect_valid = 2'b00;
    bus_a.cnt_clear = 1'b1;
    step();
    bus_a.cnt_clear = 1'b0;
    bus_a.stall_req = 4'b0001;
    bus_a.redirect_valid = 2'b11;
    bus_a.redirect_target = {32'h0000_0200, 32'h0000_0100};
    push_exp("dual_we", 64'h1);
    push_exp("dual_pc", 64'h200);
    push_exp("dual_stall", 64'h00);
    push_exp("dual_flush", 64'h02);
    #1;
    pop_chk(64'(bus_a.load_pc_we));
    pop_chk(64'(bus_a.load_pc_new_pc));
    pop_chk(64'(bus_a.hc_stall));
    pop_chk(64'(bus_a.hc_flush));
    step();
    bus_a.stall_req = 4'b0000;
    bus_a.redirect_valid = 2'b00;
    bus_a.cnt_sel = 4'd6;
    step();
    push_exp("redir1_cnt", 64'h1);
    pop_chk(64'(bus_a.cnt_rdata));
    bus_a.cnt_sel = 4'd5;
    step();
    push_exp("redir0_cnt", 64'h0);
    pop_chk(64'(bus_a.cnt_rdata));

    // No delay slot: redirect from stage 2, then gated by a D-cache miss
    bus_b.redirect_valid = 2'b10;
    bus_b.redirect_target = {32'h0000_0300, 32'h0000_0000};
    push_exp("nods_flush", 64'h06);
    push_exp("nods_stall", 64'h00);
    push_exp("nods_pc", 64'h300);
    #1;
    pop_chk(64'(bus_b.hc_flush));
    pop_chk(64'(bus_b.hc_stall));
    pop_chk(64'(bus_b.load_pc_new_pc));
    bus_b.stall_req = 4'b1000;
    push_exp("dmiss_stall", 64'h0F);
    push_exp("dmiss_flush", 64'h10);
    push_exp("dmiss_we", 64'h0);
    #1;
    pop_chk(64'(bus_b.hc_stall));
    pop_chk(64'(bus_b.hc_flush));
    pop_chk(64'(bus_b.load_pc_we));
    bus_b.stall_req = 4'b0000;
    bus_b.redirect_valid = 2'b00;
    step();

    // Watchdog: 8 consecutive fetch stalls
    bus_a.cnt_clear = 1'b1;
    step();
    bus_a.cnt_clear = 1'b0;
    bus_a.stall_req = 4'b0001;
    repeat (7) step();
    push_exp("wdog_7", 64'h0);
    pop_chk(64'(bus_a.wdog_timeout));
    step();
    push_exp("wdog_8", 64'h1);
    pop_chk(64'(bus_a.wdog_timeout));
    bus_a.stall_req = 4'b0000;
    step();
    push_exp("wdog_sticky", 64'h1);
    pop_chk(64'(bus_a.wdog_timeout));
    bus_a.cnt_clear = 1'b1;
    step();
    bus_a.cnt_clear = 1'b0;
    push_exp("wdog_clr", 64'h0);
    pop_chk(64'(bus_a.wdog_timeout));

    // D-cache miss counter, out-of-range select, clear, cycle counter
    bus_a.cnt_clear = 1'b1;
    step();
    bus_a.cnt_clear = 1'b0;
    bus_a.stall_req = 4'b1000;
    repeat (5) step();
    bus_a.stall_req = 4'b0000;
    bus_a.cnt_sel = 4'd4;
    step();
    push_exp("dmiss_cnt", 64'h5);
    pop_chk(64'(bus_a.cnt_rdata));
    bus_a.cnt_sel = 4'd15;
    step();
    push_exp("sel_oor", 64'h0);
    pop_chk(64'(bus_a.cnt_rdata));
    bus_a.cnt_sel = 4'd4;
    bus_a.cnt_clear = 1'b1;
    step();
    bus_a.cnt_clear = 1'b0;
    step();
    push_exp("cnt_clr", 64'h0);
    pop_chk(64'(bus_a.cnt_rdata));
    bus_a.cnt_clear = 1'b1;
    step();
    bus_a.cnt_clear = 1'b0;
    bus_a.cnt_sel = 4'd0;
    step();
    step();
    push_exp("cycle_cnt", 64'h1);
    pop_chk(64'(bus_a.cnt_rdata));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
Parametrised successor to the fixed five-stage hazard controller. It takes per-stage stall requests and prioritised redirect requests from an arbitrary-depth in-order pipeline. From these it generates per-boundary stall and flush controls and the PC load, with optional delay-slot semantics. It also holds saturating hazard performance counters, a fetch-starvation watchdog, and a registered counter read port. It sits beside the pipeline registers and drives every pipeline register's hazard control.

Parameters:
NUM_STAGES, 5, pipeline stages; stage 0 = fetch, stage NUM_STAGES-1 = writeback.
NUM_REDIRECT, 2, redirect sources; source r lives in stage REDIR_BASE+r; higher r = older = higher priority.
REDIR_BASE, 1, stage index of redirect source 0; REDIR_BASE+NUM_REDIRECT-1 < NUM_STAGES-1.
DELAY_SLOT, 1, 1 = MIPS delay slot (instruction behind redirecting stage survives); 0 = none.
PC_WIDTH, 32, PC width.
CNT_WIDTH, 32, counter width.
SEL_WIDTH, 4, counter select width; must cover NUM_STAGES+NUM_REDIRECT entries.
WDOG_LIMIT, 1024, consecutive fetch-stall cycles that trigger timeout; 0 disables.

Ports:
clk  in  1  clock.
rst_n  in  1  reset, asynchronous, active-low.
stall_req  in  NUM_STAGES-1  bit i: stage i cannot advance (e.g. i=0 I-cache miss, i=1 load-use, i=3 D-cache miss).
redirect_valid  in  NUM_REDIRECT  bit r: source r requests PC redirect.
redirect_target  in  NUM_REDIRECT*PC_WIDTH  target of source r at slice r.
hc_stall  out  NUM_STAGES  bit i: hold the register feeding stage i (bit 0 = PC register).
hc_flush  out  NUM_STAGES  bit i: bubble the register feeding stage i; bit 0 is always 0.
load_pc_we  out  1  PC overload enable.
load_pc_new_pc  out  PC_WIDTH  PC overload value.
cnt_sel  in  SEL_WIDTH  counter select.
cnt_clear  in  1  synchronous clear of all counters and the timeout flag.
cnt_rdata  out  CNT_WIDTH  selected counter, registered.
wdog_timeout  out  1  sticky fetch-starvation flag.

Behaviour:
- Stall/flush and load_pc are combinational, same cycle. Counters, cnt_rdata, watchdog and wdog_timeout are registered.
- hc_stall[NUM_STAGES-1] = 0.
- For i ≥ 1: hc_stall[i] = stall_req[i] | hc_stall[i+1], where stall_req is 0 for the last stage.
- Redirect acceptance: source r at stage s = REDIR_BASE+r is accepted iff redirect_valid[r] & ~hc_stall[s]. A stalled redirect is ignored that cycle and must be held by its source.
- Winner = highest accepted r. load_pc_we = any accepted. load_pc_new_pc = winner's target, else 0.
- hc_stall[0] = (stall_req[0] & ~load_pc_we) | hc_stall[1]. A redirect overrides a fetch miss; a downstream stall overrides the redirect.
- Hazard flush: hc_flush[i+1] |= stall_req[i] & ~hc_stall[i+1], for i = 0..NUM_STAGES-2. Stall wins over flush.
- Redirect flush: winner at stage s sets hc_flush[k] for 1 ≤ k ≤ s-DELAY_SLOT. With DELAY_SLOT=1 and s=1, no flush occurs. OR'd with the hazard flush.
- Counters, all saturating at all-ones:
  - index 0: cycles.
  - index 1+i: cycles with stall_req[i] = 1.
  - index NUM_STAGES+r: accepted redirects won by r.
- Out-of-range cnt_sel reads 0. cnt_rdata is updated one cycle after cnt_sel, reflecting counter values before that edge's increment.
- cnt_clear zeroes all counters and wdog_timeout at the next edge. Clear beats increment in the same cycle.
- Watchdog: a counter increments each cycle hc_stall[0] & ~load_pc_we, and resets to 0 otherwise. On reaching WDOG_LIMIT, wdog_timeout is set and stays set until cnt_clear or reset. The counter saturates at WDOG_LIMIT.
- Reset: all counters, watchdog count, cnt_rdata and wdog_timeout = 0. Combinational outputs follow inputs. Reset mid-stall leaves no pending state.

Test Plan:
- Default params, stall_req=5'b00001 (I-cache miss) -> hc_stall=5'b00001, hc_flush=5'b00010, load_pc_we=0.
- stall_req[1]=1 (load-use) with redirect_valid[0]=1 -> hc_stall=5'b00011, hc_flush=5'b00100, load_pc_we=0 (DEC redirect gated). Next cycle stall_req=0 -> load_pc_we=1, hc_flush=0.
- stall_req[0]=1 and redirect_valid=2'b11 (targets 0x100, 0x200) -> load_pc_we=1, new_pc=0x200, hc_stall[0]=0, hc_flush[1]=1. Redirect counter 1 increments by 1, counter 0 does not.
- DELAY_SLOT=0, redirect source 1 only -> hc_flush=5'b00110. stall_req[3]=1 at the same time -> redirect gated, hc_stall=5'b01111, hc_flush=5'b10000.
- WDOG_LIMIT=8, stall_req[0] held 8 cycles -> wdog_timeout rises after the 8th edge and stays set after the stall drops. cnt_clear -> 0 next cycle.
- Hold stall_req[3] 5 cycles, cnt_sel=4 -> cnt_rdata=5. cnt_clear -> 0. cnt_sel=15 -> 0.
